// File: rtl/soft_rst_pkg.sv
// Shared types and constants for the soft-reset request controller.
package soft_rst_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        FIRE    = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_CMD  = 2'b01;
    localparam logic [1:0] CAUSE_WDOG = 2'b10;

    localparam logic [15:0] DEF_ARM_KEY  = 16'hA5A5;
    localparam logic [15:0] DEF_FIRE_KEY = 16'h5A5A;

    localparam logic [31:0] DEF_ARM_TIMEOUT  = 32'd59_999_999;
    localparam logic [31:0] DEF_HOLDOFF_TIME = 32'd5_999_999;
    localparam logic [31:0] DEF_WDOG_TIME    = 32'd119_999_999;

endpackage

// File: rtl/soft_rst_ctrl_wdog.sv
// Watchdog counter with a single-cycle expiry pulse; kick or disable restarts the count.
module soft_rst_wdog
    import soft_rst_pkg::*;
#(
    parameter logic [31:0] WDOG_TIME = DEF_WDOG_TIME
) (
    input  logic clk_60m,
    input  logic rst,
    input  logic wdog_en,
    input  logic wdog_kick,
    input  logic wdog_active,
    output logic wdog_expire
);

    logic [31:0] wdog_cnt;

    // A kick on the expiry cycle suppresses the fire.
    assign wdog_expire = wdog_en && wdog_active && !wdog_kick
                         && (wdog_cnt == WDOG_TIME - 32'd1);

    always_ff @(posedge clk_60m or posedge rst) begin
        if (rst) begin
            wdog_cnt <= 32'd0;
        end else if (!wdog_en || wdog_kick || !wdog_active || wdog_expire) begin
            wdog_cnt <= 32'd0;
        end else begin
            wdog_cnt <= wdog_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/soft_rst_ctrl.sv
// Soft-reset request controller: ARM/FIRE key sequence, hold-off window, optional watchdog.
// Watchdog is built only when SOFT_RST_WDOG_EN is defined.
//
// state   | meaning
// IDLE    | waiting for ARM_KEY
// ARMED   | ARM_KEY seen, waiting for FIRE_KEY before ARM_TIMEOUT
// FIRE    | one-cycle soft_rst_en strobe
// HOLDOFF | HOLDOFF_TIME cycles with all requests ignored
module soft_rst_ctrl
    import soft_rst_pkg::*;
#(
    parameter int          U_DLY        = 1,
    parameter logic [15:0] ARM_KEY      = DEF_ARM_KEY,
    parameter logic [15:0] FIRE_KEY     = DEF_FIRE_KEY,
    parameter logic [31:0] ARM_TIMEOUT  = DEF_ARM_TIMEOUT,
    parameter logic [31:0] HOLDOFF_TIME = DEF_HOLDOFF_TIME,
    parameter logic [31:0] WDOG_TIME    = DEF_WDOG_TIME
) (
    input  logic        clk_60m,
    input  logic        rst,
    input  logic        cfg_wr_en,
    input  logic [15:0] cfg_wr_data,
    input  logic        wdog_en,
    input  logic        wdog_kick,
    output logic        soft_rst_en,
    output logic        rst_busy,
    output logic [1:0]  rst_cause,
    output logic        arm_err,
    output logic [7:0]  fire_cnt
);

    state_t      state;
    logic [31:0] arm_cnt;
    logic [31:0] hold_cnt;
    logic        wdog_fire;
    logic        wr_arm;
    logic        fire_cmd;
    logic        fire_now;
    logic        unused_cfg;

`ifdef SOFT_RST_WDOG_EN
    logic wdog_active;

    assign wdog_active = (state == IDLE) || (state == ARMED);
    assign unused_cfg  = (U_DLY != 0);

    soft_rst_wdog #(
        .WDOG_TIME (WDOG_TIME)
    ) u_wdog (
        .clk_60m     (clk_60m),
        .rst         (rst),
        .wdog_en     (wdog_en),
        .wdog_kick   (wdog_kick),
        .wdog_active (wdog_active),
        .wdog_expire (wdog_fire)
    );
`else
    assign wdog_fire  = 1'b0;
    assign unused_cfg = (U_DLY != 0) ^ wdog_en ^ wdog_kick ^ (WDOG_TIME != 32'd0);
`endif

    assign wr_arm   = cfg_wr_en && (cfg_wr_data == ARM_KEY);
    assign fire_cmd = (state == ARMED) && cfg_wr_en && (cfg_wr_data == FIRE_KEY);
    // Command beats a simultaneous watchdog expiry.
    assign fire_now = fire_cmd || wdog_fire;

    always_ff @(posedge clk_60m or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            arm_cnt     <= 32'd0;
            hold_cnt    <= 32'd0;
            soft_rst_en <= 1'b0;
            rst_busy    <= 1'b0;
            rst_cause   <= CAUSE_NONE;
            arm_err     <= 1'b0;
            fire_cnt    <= 8'd0;
        end else begin
            soft_rst_en <= 1'b0;
            if (fire_now) begin
                state       <= FIRE;
                soft_rst_en <= 1'b1;
                rst_busy    <= 1'b1;
                rst_cause   <= fire_cmd ? CAUSE_CMD : CAUSE_WDOG;
                arm_err     <= 1'b0;
                if (fire_cnt != 8'hFF) begin
                    fire_cnt <= fire_cnt + 8'd1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (wr_arm) begin
                            state    <= ARMED;
                            arm_cnt  <= 32'd0;
                            rst_busy <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (wr_arm) begin
                            arm_cnt <= 32'd0;
                        end else if (cfg_wr_en || (arm_cnt == ARM_TIMEOUT - 32'd1)) begin
                            state    <= IDLE;
                            arm_err  <= 1'b1;
                            rst_busy <= 1'b0;
                        end else begin
                            arm_cnt <= arm_cnt + 32'd1;
                        end
                    end
                    FIRE: begin
                        state    <= HOLDOFF;
                        hold_cnt <= 32'd0;
                    end
                    HOLDOFF: begin
                        if (hold_cnt == HOLDOFF_TIME - 32'd1) begin
                            state    <= IDLE;
                            rst_busy <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + 32'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        rst_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
